// File: rtl/apb_master_arbiter_if.sv
// Bundle of signals between two requesters, the APB arbiter and one APB slave.
// master: the arbiter's view. slave: the view of the environment around it
// (requesters and the APB slave).
interface apb_master_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // Requester 0
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_err;
  // Requester 1
  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_err;
  // APB bus
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, req0_done, req0_rdata, req0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, req1_done, req1_rdata, req1_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, req0_done, req0_rdata, req0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, req1_done, req1_rdata, req1_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// IDLE -> SETUP -> ACCESS, with direct ACCESS -> SETUP hand-over when another
// request is pending as the current transfer completes.
// Optional feature: define APB_ARB_TIMEOUT_EN to abort an ACCESS phase that
// has waited 15 cycles on PREADY (done pulse with err=1, rdata=0).
module apb_master_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic                  PCLK,
  input logic                  PRESET,
  apb_master_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              last_q, last_d;   // requester granted most recently
  logic              id_q, id_d;       // owner of the transfer in flight
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic complete;   // ACCESS finishing normally this cycle
  logic timeout;    // ACCESS being aborted this cycle
  logic grant_pt;
  logic any_valid;
  logic gnt;        // requester chosen at this grant point
  logic accept;

`ifdef APB_ARB_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;

  assign timeout = (state_q == ACCESS) && !bus.PREADY && (cnt_q == 4'hF);

  // Wait-state counter: cleared on the way into ACCESS, counts PREADY=0 cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = 4'h0;
    end else if ((state_q == ACCESS) && !bus.PREADY) begin
      cnt_d = cnt_q + 4'h1;
    end
  end

  // Counter register.
  always_ff @(posedge PCLK) begin
    if (PRESET) cnt_q <= 4'h0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign complete  = (state_q == ACCESS) && bus.PREADY;
  assign grant_pt  = !PRESET && ((state_q == IDLE) || complete);
  assign any_valid = bus.req0_valid || bus.req1_valid;
  // Tie goes to the requester not granted last; otherwise the only one asking.
  assign gnt       = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
  assign accept    = grant_pt && any_valid;

  assign bus.req0_ready = accept && !gnt;
  assign bus.req1_ready = accept && gnt;

  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;

  assign bus.req0_done  = done0_q;
  assign bus.req0_err   = err0_q;
  assign bus.req0_rdata = rdata0_q;
  assign bus.req1_done  = done1_q;
  assign bus.req1_err   = err1_q;
  assign bus.req1_rdata = rdata1_q;

  // Next-state, APB outputs, grant bookkeeping and completion reporting.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    last_d    = last_q;
    id_d      = id_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = '0;
    rdata1_d  = '0;

    // Completion report goes to the owner of the finishing transfer.
    if (complete || timeout) begin
      if (!id_q) begin
        done0_d  = 1'b1;
        err0_d   = timeout || bus.PSLVERR;
        rdata0_d = (pwrite_q || timeout) ? '0 : bus.PRDATA;
      end else begin
        done1_d  = 1'b1;
        err1_d   = timeout || bus.PSLVERR;
        rdata1_d = (pwrite_q || timeout) ? '0 : bus.PRDATA;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (timeout) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end else if (bus.PREADY) begin
          if (accept) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
          end else begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    // Transfer fields are captured only on acceptance and held until the next.
    if (accept) begin
      last_d   = gnt;
      id_d     = gnt;
      pwrite_d = gnt ? bus.req1_write : bus.req0_write;
      paddr_d  = gnt ? bus.req1_addr  : bus.req0_addr;
      pwdata_d = gnt ? bus.req1_wdata : bus.req0_wdata;
    end
  end

  // State register; reset abandons any in-flight transfer silently.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      last_q    <= last_d;
      id_q      <= id_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: reset, single write, contention,
// wait-state read, slave error, reset mid-ACCESS and long PREADY stall
// (timeout or indefinite wait depending on APB_ARB_TIMEOUT_EN).
module tb_apb_master_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   done_seen;

  always #5 clk = ~clk;

  apb_master_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  apb_master_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
    bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
    bus.PRDATA = 32'hFFFF0000; bus.PREADY = 1; bus.PSLVERR = 0;
    tick(); tick();

    // Reset state; ready held low while in reset even with a request.
    bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 8'h10; bus.req0_wdata = 32'hDEADBEEF;
    #1;
    check("rst_psel", bus.PSEL, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    check("rst_pwrite", bus.PWRITE, 0);
    check("rst_done0", bus.req0_done, 0);
    check("rst_done1", bus.req1_done, 0);
    check("rst_ready0", bus.req0_ready, 0);

    // Single write from req0.
    rst = 0; #1;
    check("w_ready0", bus.req0_ready, 1);
    check("w_ready1", bus.req1_ready, 0);
    tick(); bus.req0_valid = 0; #1;
    check("w_setup_psel", bus.PSEL, 1);
    check("w_setup_pen", bus.PENABLE, 0);
    check("w_paddr", bus.PADDR, 8'h10);
    check("w_pwdata", bus.PWDATA, 32'hDEADBEEF);
    check("w_pwrite", bus.PWRITE, 1);
    check("w_setup_noready", bus.req0_ready, 0);
    tick();
    check("w_access_psel", bus.PSEL, 1);
    check("w_access_pen", bus.PENABLE, 1);
    check("w_access_done", bus.req0_done, 0);
    tick();
    check("w_idle_psel", bus.PSEL, 0);
    check("w_done0", bus.req0_done, 1);
    check("w_err0", bus.req0_err, 0);
    check("w_rdata0_write", bus.req0_rdata, 0);
    check("w_done1", bus.req1_done, 0);
    tick();
    check("w_done_pulse", bus.req0_done, 0);

    // Contention after reset: 0,1,0,1 back to back.
    rst = 1; tick(); rst = 0;
    bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 8'hA0; bus.req0_wdata = 32'h000000A0;
    bus.req1_valid = 1; bus.req1_write = 1; bus.req1_addr = 8'hB0; bus.req1_wdata = 32'h000000B0;
    #1;
    check("c_ready0_first", bus.req0_ready, 1);
    check("c_ready1_first", bus.req1_ready, 0);
    tick();
    check("c_paddr_1", bus.PADDR, 8'hA0);
    tick();
    check("c_ready1_second", bus.req1_ready, 1);
    check("c_ready0_second", bus.req0_ready, 0);
    tick();
    check("c_b2b_psel", bus.PSEL, 1);
    check("c_b2b_pen", bus.PENABLE, 0);
    check("c_paddr_2", bus.PADDR, 8'hB0);
    check("c_done0", bus.req0_done, 1);
    tick();
    check("c_ready0_third", bus.req0_ready, 1);
    tick();
    check("c_paddr_3", bus.PADDR, 8'hA0);
    check("c_done1", bus.req1_done, 1);
    tick();
    check("c_ready1_fourth", bus.req1_ready, 1);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    check("c_paddr_4", bus.PADDR, 8'hB0);
    check("c_psel_4", bus.PSEL, 1);
    tick(); tick();
    check("c_end_idle", bus.PSEL, 0);
    check("c_end_done1", bus.req1_done, 1);

    // Read from req1 with three wait states.
    bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 8'h04;
    #1;
    check("r_ready1", bus.req1_ready, 1);
    tick(); bus.req1_valid = 0; bus.PREADY = 0; bus.PRDATA = 32'h12345678;
    check("r_pwrite", bus.PWRITE, 0);
    check("r_paddr", bus.PADDR, 8'h04);
    tick();
    check("r_wait1_pen", bus.PENABLE, 1);
    check("r_wait1_noready", bus.req1_ready, 0);
    tick();
    check("r_wait2_pen", bus.PENABLE, 1);
    tick();
    check("r_wait3_pen", bus.PENABLE, 1);
    check("r_wait3_done", bus.req1_done, 0);
    bus.PREADY = 1;
    tick();
    check("r_done1", bus.req1_done, 1);
    check("r_rdata1", bus.req1_rdata, 32'h12345678);
    check("r_err1", bus.req1_err, 0);
    check("r_idle", bus.PSEL, 0);

    // Slave error on a req0 write, then a clean req1 read.
    bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 8'h20; bus.req0_wdata = 32'h55;
    tick(); bus.req0_valid = 0; bus.PSLVERR = 1;
    tick();
    tick(); bus.PSLVERR = 0;
    check("e_done0", bus.req0_done, 1);
    check("e_err0", bus.req0_err, 1);
    bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 8'h30; bus.PRDATA = 32'hCAFE0001;
    #1;
    check("e_next_ready1", bus.req1_ready, 1);
    tick(); bus.req1_valid = 0;
    tick(); tick();
    check("e_next_done1", bus.req1_done, 1);
    check("e_next_err1", bus.req1_err, 0);
    check("e_next_rdata1", bus.req1_rdata, 32'hCAFE0001);

    // Reset during a wait state; pointer returns to favour req0.
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 8'h40;
    tick(); bus.req0_valid = 0; bus.PREADY = 0;
    tick();
    check("m_in_access", bus.PENABLE, 1);
    tick();
    rst = 1; bus.PREADY = 1;
    tick();
    check("m_psel", bus.PSEL, 0);
    check("m_pen", bus.PENABLE, 0);
    check("m_no_done0", bus.req0_done, 0);
    rst = 0;
    bus.req0_valid = 1; bus.req0_addr = 8'h41; bus.req1_valid = 1; bus.req1_addr = 8'h42;
    #1;
    check("m_tie_ready0", bus.req0_ready, 1);
    check("m_tie_ready1", bus.req1_ready, 0);
    tick(); bus.req0_valid = 0; bus.req1_valid = 0;
    check("m_no_done0_late", bus.req0_done, 0);
    check("m_paddr", bus.PADDR, 8'h41);
    tick(); tick();
    check("m_done0", bus.req0_done, 1);

    // Long stall on PREADY.
    bus.req1_valid = 1; bus.req1_write = 1; bus.req1_addr = 8'h50; bus.req1_wdata = 32'h77;
    tick(); bus.req1_valid = 0; bus.PREADY = 0;
    tick();
    check("t_enter_access", bus.PENABLE, 1);
    done_seen = 0;
`ifdef APB_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.req1_done) done_seen++;
    end
    check("t_still_access", bus.PSEL, 1);
    check("t_no_early_done", done_seen, 0);
    tick();
    check("t_psel", bus.PSEL, 0);
    check("t_pen", bus.PENABLE, 0);
    check("t_done1", bus.req1_done, 1);
    check("t_err1", bus.req1_err, 1);
    check("t_rdata1", bus.req1_rdata, 0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.req1_done) done_seen++;
    end
    check("s_psel", bus.PSEL, 1);
    check("s_pen", bus.PENABLE, 1);
    check("s_no_done", done_seen, 0);
`endif
    rst = 1; bus.PREADY = 1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001: Parameter ADDR_W, default 8, APB address width in bits.
REQ-002: Parameter DATA_W, default 32, APB data width in bits.
REQ-003: Port PCLK  input  1  sole clock; all state updates on rising edge.
REQ-004: Port PRESET  input  1  synchronous, active-high reset, sampled on rising PCLK.
REQ-005: Ports reqN_valid (N=0,1)  input  1  requester N has a transfer pending; fields are held stable until accepted.
REQ-006: Ports reqN_write  input  1; reqN_addr  input  ADDR_W; reqN_wdata  input  DATA_W  transfer direction, address and write data.
REQ-007: Ports reqN_ready  output  1  combinational accept; the transfer is taken when reqN_valid & reqN_ready.
REQ-008: Ports reqN_done  output  1  registered one-cycle completion pulse; reqN_rdata  output  DATA_W; reqN_err  output  1; rdata/err are valid only while done is high.
REQ-009: Ports PSEL, PENABLE, PWRITE  output  1; PADDR  output  ADDR_W; PWDATA  output  DATA_W  APB master side, all registered.
REQ-010: Ports PRDATA  input  DATA_W; PREADY  input  1; PSLVERR  input  1  APB slave response.

Function
REQ-011: FSM states are IDLE, SETUP and ACCESS.
REQ-012: In IDLE, PSEL=0 and PENABLE=0.
REQ-013: A grant point is IDLE, or ACCESS with PREADY=1; at a grant point with at least one reqN_valid, exactly one reqN_ready is asserted and the state goes to SETUP.
REQ-014: Round-robin arbitration: when both requesters are valid, grant the one not granted last; when one is valid, grant it.
REQ-015: The last-granted pointer updates only on an accepted grant.
REQ-016: On acceptance, PADDR, PWDATA and PWRITE latch the granted requester's fields and the granted requester id is stored.
REQ-017: PADDR, PWDATA and PWRITE do not change again until the next acceptance.
REQ-018: SETUP lasts exactly one cycle (PSEL=1, PENABLE=0), then ACCESS.
REQ-019: ACCESS holds PSEL=1, PENABLE=1 and inserts a wait state for every cycle PREADY=0.
REQ-020: On ACCESS with PREADY=1, the next cycle pulses done for the stored requester only, with rdata=PRDATA (0 for writes) and err=PSLVERR, both sampled in the completing cycle.
REQ-021: On ACCESS with PREADY=1 and no valid request, the state goes to IDLE.
REQ-022: On ACCESS with PREADY=1 and a valid request, the state goes directly to SETUP (back-to-back; PSEL stays 1 and PENABLE drops).
REQ-023: Minimum transfer is 2 PCLK (SETUP plus zero-wait ACCESS).
REQ-024: A requester may be accepted in the same cycle its previous transfer completes; its done pulse for the earlier transfer still occurs in the following cycle.
REQ-025: No reqN_ready is asserted in SETUP, or in ACCESS with PREADY=0.
REQ-026: reqN_valid deasserted before acceptance is permitted; no transfer is issued for it.

Reset
REQ-027: PRESET=1 forces IDLE on the next edge, including mid-SETUP or mid-ACCESS; the in-flight transfer is abandoned with no done pulse.
REQ-028: Reset values are PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, all done=0, err=0, rdata=0, pointer=1 (requester 0 wins the first tie) and timeout counter=0.
REQ-029: While PRESET=1, reqN_ready is 0.

Configuration
REQ-030: Macro APB_ARB_TIMEOUT_EN defined: a 4-bit counter clears on entering ACCESS and increments on each ACCESS cycle with PREADY=0.
REQ-031: With APB_ARB_TIMEOUT_EN, when the counter equals 15 and PREADY=0, the transfer is terminated: next state IDLE, PSEL=0, PENABLE=0, done pulse with err=1 and rdata=0.
REQ-032: With APB_ARB_TIMEOUT_EN, a timeout cycle is not a grant point.
REQ-033: Macro APB_ARB_TIMEOUT_EN undefined: there is no counter, ACCESS waits indefinitely for PREADY, and err reflects PSLVERR only.

Verification
REQ-034: Single write: req0 write addr 0x10 data 0xDEADBEEF, PREADY=1 -> SETUP then ACCESS with PADDR=0x10, PWDATA=0xDEADBEEF, PWRITE=1; req0_done=1, req0_err=0 on the next cycle.
REQ-035: Contention: req0 and req1 valid continuously after reset -> grants alternate 0,1,0,1; back-to-back transfers with no IDLE cycle.
REQ-036: Read with wait states: req1 read addr 0x04, PREADY low 3 cycles, PRDATA=0x12345678 -> ACCESS lasts 4 cycles; req1_rdata=0x12345678, req1_err=0.
REQ-037: Slave error: PSLVERR=1 with PREADY=1 -> done with err=1; the next transfer proceeds normally.
REQ-038: Reset mid-ACCESS: PRESET pulsed during a wait state -> IDLE, PSEL=0, no done pulse; the next tie is granted to req0.
REQ-039: APB_ARB_TIMEOUT_EN defined, PREADY held 0 -> after 16 ACCESS cycles PSEL=0, done with err=1 and rdata=0.
REQ-040: APB_ARB_TIMEOUT_EN undefined, PREADY held 0 for 100 cycles -> still in ACCESS, no done pulse.
